// File: rtl/vga_pkg.sv
// vga_pkg: shared video-timing constants for the pipeline.
//   HOR_PIXELS/VER_PIXELS define the visible area. The porch, sync and
//   total localparams describe 800x600@60 with a 40 MHz pixel clock.
//   vga_cnt_t is the raster counter type. An 11-bit counter covers totals
//   up to 2048.
package vga_pkg;

   localparam int HOR_PIXELS = 800;
   localparam int VER_PIXELS = 600;

   localparam int H_FP    = 40;
   localparam int H_SYNC  = 128;
   localparam int H_BP    = 88;
   localparam int H_TOTAL = HOR_PIXELS + H_FP + H_SYNC + H_BP;

   localparam int V_FP    = 1;
   localparam int V_SYNC  = 4;
   localparam int V_BP    = 23;
   localparam int V_TOTAL = VER_PIXELS + V_FP + V_SYNC + V_BP;

   localparam bit HS_POL = 1'b1;
   localparam bit VS_POL = 1'b1;

   typedef logic [10:0] vga_cnt_t;

endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one raster axis. It holds a wrapping position counter plus
// registered blank and sync decode.
//   clk     in   pixel clock
//   rst     in   synchronous active-high reset; position returns to 0
//   en_i    in   advance the counter by one this clock
//   cnt_o   out  current position, 0 .. TOTAL-1
//   blnk_o  out  1 when cnt_o >= ACTIVE
//   sync_o  out  POL while ACTIVE+FP <= cnt_o < ACTIVE+FP+SYNC, else ~POL
//   wrap_o  out  combinational: the next enabled clock wraps the counter to 0
// The flags are decoded from the next-state count and registered with it.
// This keeps them exactly aligned with cnt_o.
module vga_axis_cnt
   import vga_pkg::*;
#(
   parameter int ACTIVE = HOR_PIXELS,
   parameter int FP     = H_FP,
   parameter int SYNC   = H_SYNC,
   parameter int BP     = H_BP,
   parameter bit POL    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   output logic [10:0] cnt_o,
   output logic        blnk_o,
   output logic        sync_o,
   output logic        wrap_o
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;

   localparam vga_cnt_t LAST       = vga_cnt_t'(TOTAL - 1);
   localparam vga_cnt_t BLNK_START = vga_cnt_t'(ACTIVE);
   localparam vga_cnt_t SYNC_START = vga_cnt_t'(ACTIVE + FP);
   localparam vga_cnt_t SYNC_END   = vga_cnt_t'(ACTIVE + FP + SYNC);

   generate
      if (TOTAL > 2048 || ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_geometry
         $error("vga_axis_cnt: illegal geometry (total must be <= 2048, every segment >= 1)");
      end
   endgenerate

   vga_cnt_t cnt_q, cnt_d;
   logic     blnk_q, blnk_d;
   logic     sync_q, sync_d;

   always_comb begin
      cnt_d = cnt_q;
      if (rst) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 11'd1;
      end
      blnk_d = (cnt_d >= BLNK_START);
      sync_d = ((cnt_d >= SYNC_START) && (cnt_d < SYNC_END)) ? POL : ~POL;
   end

   always_ff @(posedge clk) begin
      cnt_q  <= cnt_d;
      blnk_q <= blnk_d;
      sync_q <= sync_d;
   end

   assign cnt_o  = cnt_q;
   assign blnk_o = blnk_q;
   assign sync_o = sync_q;
   assign wrap_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/vga_timing.sv
// vga_timing: free-running raster timing generator. This is the first stage
// of the video pipeline.
//   clk          in   pixel clock
//   rst          in   synchronous active-high reset to pixel (0,0)
//   hcount_o     out  horizontal position [10:0]
//   hsync_o      out  horizontal sync, active level HS_POL
//   hblnk_o      out  horizontal blanking
//   vcount_o     out  vertical position (line) [10:0]
//   vsync_o      out  vertical sync, active level VS_POL
//   vblnk_o      out  vertical blanking
//   rgb_o        out  always black; downstream stages paint the pixels
//   sof_o        out  high while the outputs present pixel (0,0)
//   frame_cnt_o  out  completed-frame counter, wraps modulo 2^16
// All outputs are registered and aligned to the same pixel.
module vga_timing #(
   parameter int H_ACTIVE = vga_pkg::HOR_PIXELS,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::VER_PIXELS,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP,
   parameter bit HS_POL   = vga_pkg::HS_POL,
   parameter bit VS_POL   = vga_pkg::VS_POL
) (
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] vcount_o,
   output logic        vsync_o,
   output logic        vblnk_o,
   output logic [10:0] hcount_o,
   output logic        hsync_o,
   output logic        hblnk_o,
   output logic [11:0] rgb_o,
   output logic        sof_o,
   output logic [15:0] frame_cnt_o
);

   import vga_pkg::*;

   logic        h_wrap;
   logic        v_wrap;
   logic        frame_end;
   logic        sof_q, sof_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   vga_axis_cnt #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HS_POL)
   ) u_h_cnt (
      .clk    (clk),
      .rst    (rst),
      .en_i   (1'b1),
      .cnt_o  (hcount_o),
      .blnk_o (hblnk_o),
      .sync_o (hsync_o),
      .wrap_o (h_wrap)
   );

   // The vertical axis steps once per line, on the clock where hcount wraps.
   vga_axis_cnt #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VS_POL)
   ) u_v_cnt (
      .clk    (clk),
      .rst    (rst),
      .en_i   (h_wrap),
      .cnt_o  (vcount_o),
      .blnk_o (vblnk_o),
      .sync_o (vsync_o),
      .wrap_o (v_wrap)
   );

   // v_wrap can only be high when h_wrap is high, so it marks the last pixel.
   assign frame_end = v_wrap;

   always_comb begin
      sof_d       = rst | frame_end;
      frame_cnt_d = frame_cnt_q;
      if (rst) begin
         frame_cnt_d = '0;
      end else if (frame_end) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      sof_q       <= sof_d;
      frame_cnt_q <= frame_cnt_d;
   end

   assign sof_o       = sof_q;
   assign frame_cnt_o = frame_cnt_q;
   assign rgb_o       = 12'h000;

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;
  bit mon_en = 1'b0;

  // default 800x600 instance
  logic [10:0] hcount, vcount;
  logic        hsync, vsync, hblnk, vblnk, sof;
  logic [11:0] rgb;
  logic [15:0] frame_cnt;

  // small instance with active-low syncs: H 8/2/3/2 (15), V 6/1/2/1 (10), 150 clk per frame
  logic [10:0] hcount_s, vcount_s;
  logic        hsync_s, vsync_s, hblnk_s, vblnk_s, sof_s;
  logic [11:0] rgb_s;
  logic [15:0] frame_cnt_s;

  vga_timing dut (
    .clk         (clk),
    .rst         (rst),
    .vcount_o    (vcount),
    .vsync_o     (vsync),
    .vblnk_o     (vblnk),
    .hcount_o    (hcount),
    .hsync_o     (hsync),
    .hblnk_o     (hblnk),
    .rgb_o       (rgb),
    .sof_o       (sof),
    .frame_cnt_o (frame_cnt)
  );

  vga_timing #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL   (1'b0), .VS_POL (1'b0)
  ) dut_s (
    .clk         (clk),
    .rst         (rst_s),
    .vcount_o    (vcount_s),
    .vsync_o     (vsync_s),
    .vblnk_o     (vblnk_s),
    .hcount_o    (hcount_s),
    .hsync_o     (hsync_s),
    .hblnk_o     (hblnk_s),
    .rgb_o       (rgb_s),
    .sof_o       (sof_s),
    .frame_cnt_o (frame_cnt_s)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    if (t > k) tick(t - k);
    k = t;
  endtask

  // {hblnk, hsync, vblnk, vsync} derived from a position and a geometry
  function automatic logic [3:0] dec(input int h, input int v,
                                     input int ha, input int hfp, input int hs,
                                     input int va, input int vfp, input int vs,
                                     input bit hp, input bit vp);
    logic hb, hy, vb, vy;
    hb = (h >= ha);
    hy = (h >= ha + hfp && h < ha + hfp + hs) ? hp : ~hp;
    vb = (v >= va);
    vy = (v >= va + vfp && v < va + vfp + vs) ? vp : ~vp;
    return {hb, hy, vb, vy};
  endfunction

  // every-cycle flag/rgb consistency on both instances
  always @(negedge clk) begin
    if (mon_en) begin
      check("dec_default", {16'h0, hblnk, hsync, vblnk, vsync, rgb},
            {16'h0, dec(int'(hcount), int'(vcount), 800, 40, 128, 600, 1, 4, 1'b1, 1'b1), 12'h000});
      check("dec_small", {16'h0, hblnk_s, hsync_s, vblnk_s, vsync_s, rgb_s},
            {16'h0, dec(int'(hcount_s), int'(vcount_s), 8, 2, 3, 6, 1, 2, 1'b0, 1'b0), 12'h000});
    end
  end

  initial begin
    // test 1: reset held 5 clocks
    tick(5);
    mon_en = 1'b1;
    check("rst_hcount", 32'(hcount), 32'd0);
    check("rst_vcount", 32'(vcount), 32'd0);
    check("rst_sof", 32'(sof), 32'd1);
    check("rst_syncs", {30'h0, hsync, vsync}, 32'h0);
    check("rst_blnks", {30'h0, hblnk, vblnk}, 32'h0);
    check("rst_frame", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    k = 0;
    check("rel_hcount", 32'(hcount), 32'd0);
    check("rel_sof", 32'(sof), 32'd1);
    goto(1);
    check("h1_hcount", 32'(hcount), 32'd1);
    check("h1_sof", 32'(sof), 32'd0);

    // test 2: one line on the default geometry
    goto(799);  check("h799_hblnk", 32'(hblnk), 32'd0);
    goto(800);  check("h800_hblnk", 32'(hblnk), 32'd1);
                check("h800_hsync", 32'(hsync), 32'd0);
    goto(839);  check("h839_hsync", 32'(hsync), 32'd0);
    goto(840);  check("h840_hsync", 32'(hsync), 32'd1);
    goto(967);  check("h967_hsync", 32'(hsync), 32'd1);
    goto(968);  check("h968_hsync", 32'(hsync), 32'd0);
    goto(1055); check("h1055_hcount", 32'(hcount), 32'd1055);
                check("h1055_vcount", 32'(vcount), 32'd0);
    goto(1056); check("wrap_hcount", 32'(hcount), 32'd0);
                check("wrap_vcount", 32'(vcount), 32'd1);
                check("wrap_sof", 32'(sof), 32'd0);
                check("wrap_hblnk", 32'(hblnk), 32'd0);

    // test 5 (default): reset in mid-line
    goto(1556);
    check("mid_hcount", 32'(hcount), 32'd500);
    check("mid_vcount", 32'(vcount), 32'd1);
    rst = 1'b1;
    tick(1);
    check("mrst_pos", {5'h0, hcount, 5'h0, vcount}, 32'h0);
    check("mrst_sof", 32'(sof), 32'd1);
    check("mrst_flags", {28'h0, hblnk, hsync, vblnk, vsync}, 32'h0);
    rst = 1'b0;

    // tests 3/4: full frame on the small active-low instance
    rst_s = 1'b0;
    k = 0;
    check("s_rel_sof", 32'(sof_s), 32'd1);
    check("s_rel_syncs", {30'h0, hsync_s, vsync_s}, 32'h3);
    goto(8);   check("s_h8_hblnk", 32'(hblnk_s), 32'd1);
               check("s_h8_hsync", 32'(hsync_s), 32'd1);
    goto(10);  check("s_h10_hsync", 32'(hsync_s), 32'd0);
    goto(12);  check("s_h12_hsync", 32'(hsync_s), 32'd0);
    goto(13);  check("s_h13_hsync", 32'(hsync_s), 32'd1);
    goto(15);  check("s_wrap_pos", {5'h0, hcount_s, 5'h0, vcount_s}, {16'h0, 16'd1});
    goto(89);  check("s_v5_vblnk", 32'(vblnk_s), 32'd0);
    goto(90);  check("s_v6_vblnk", 32'(vblnk_s), 32'd1);
               check("s_v6_pos", {5'h0, hcount_s, 5'h0, vcount_s}, {16'h0, 16'd6});
    goto(104); check("s_v6_vsync", 32'(vsync_s), 32'd1);
    goto(105); check("s_v7_vsync", 32'(vsync_s), 32'd0);
    goto(134); check("s_v8_vsync", 32'(vsync_s), 32'd0);
    goto(135); check("s_v9_vsync", 32'(vsync_s), 32'd1);
    goto(149); check("s_last_sof", 32'(sof_s), 32'd0);
               check("s_last_frame", 32'(frame_cnt_s), 32'd0);
    goto(150); check("s_sof", 32'(sof_s), 32'd1);
               check("s_frame1", 32'(frame_cnt_s), 32'd1);
               check("s_sof_pos", {5'h0, hcount_s, 5'h0, vcount_s}, 32'h0);
    goto(151); check("s_sof_end", 32'(sof_s), 32'd0);

    // test 5 (small): reset at v=5, h=5 clears the frame counter too
    goto(230);
    check("s_mid_pos", {5'h0, hcount_s, 5'h0, vcount_s}, {16'd5, 16'd5});
    rst_s = 1'b1;
    tick(1);
    check("s_mrst_pos", {5'h0, hcount_s, 5'h0, vcount_s}, 32'h0);
    check("s_mrst_frame", 32'(frame_cnt_s), 32'd0);
    check("s_mrst_sof", 32'(sof_s), 32'd1);
    check("s_mrst_flags", {28'h0, hblnk_s, hsync_s, vblnk_s, vsync_s}, 32'h5);
    rst_s = 1'b0;
    k = 0;

    // test 6: preload the frame counter to 65535 and wrap on the next sof
    goto(20);
    force dut_s.frame_cnt_q = 16'hffff;
    tick(1);
    k = 21;
    release dut_s.frame_cnt_q;
    check("s_preload", 32'(frame_cnt_s), 32'hffff);
    goto(149); check("s_pre_wrap", 32'(frame_cnt_s), 32'hffff);
    goto(150); check("s_wrap_frame", 32'(frame_cnt_s), 32'd0);
               check("s_wrap_sof", 32'(sof_s), 32'd1);

    tick(2);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
